// File: rtl/hex_update_seq.sv
// Burst-write sequencer that pushes a 32-bit value into the hex_sb_ctrl digit and mask registers.
// Define HEX_SEQ_SKIP_UNCHANGED_EN to skip writes of digits equal to the last completed value.
module hex_update_seq #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] value_i,
    input  logic [7:0]  mask_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o
);

    localparam bit         GapEn   = (GAP_CYCLES != 0);
    localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StDigit, StGap, StMask, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        gap_mask_q, gap_mask_d;
    logic [31:0] act_val_q, act_val_d;
    logic [7:0]  act_mask_q, act_mask_d;
    logic [31:0] pend_val_q, pend_val_d;
    logic [7:0]  pend_mask_q, pend_mask_d;
    logic        pend_vld_q, pend_vld_d;
`ifdef HEX_SEQ_SKIP_UNCHANGED_EN
    logic [31:0] shadow_q, shadow_d;
`endif

    logic        busy_d, done_d, req_d;
    logic [31:0] addr_d, wdata_d;

    logic        launch;
    logic [3:0]  from_idx;
    logic [3:0]  tgt_idx;
    logic [31:0] changed;

    // First digit index >= from whose nibble needs writing; 8 means none remain.
    function automatic logic [3:0] find_write(input logic [3:0] from, input logic [31:0] diff);
        logic [3:0] r;
        r = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (4'(k) >= from && diff[4*k +: 4] != 4'h0) r = 4'(k);
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        gap_mask_d  = gap_mask_q;
        act_val_d   = act_val_q;
        act_mask_d  = act_mask_q;
        pend_val_d  = pend_val_q;
        pend_mask_d = pend_mask_q;
        pend_vld_d  = pend_vld_q;
`ifdef HEX_SEQ_SKIP_UNCHANGED_EN
        shadow_d    = shadow_q;
`endif
        launch      = 1'b0;
        from_idx    = 4'd0;
        tgt_idx     = 4'd0;
        changed     = '1;

        if (start_i && state_q != StIdle && state_q != StDone) begin
            pend_val_d  = value_i;
            pend_mask_d = mask_i;
            pend_vld_d  = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    act_val_d  = value_i;
                    act_mask_d = mask_i;
                    launch     = 1'b1;
                end
            end
            StDigit: begin
                if (GapEn) begin
                    state_d    = StGap;
                    gap_cnt_d  = 4'd0;
                    gap_mask_d = 1'b0;
                end else begin
                    launch   = 1'b1;
                    from_idx = {1'b0, idx_q} + 4'd1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    if (gap_mask_q) begin
                        state_d = StDone;
                    end else begin
                        launch   = 1'b1;
                        from_idx = {1'b0, idx_q} + 4'd1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            StMask: begin
                if (GapEn) begin
                    state_d    = StGap;
                    gap_cnt_d  = 4'd0;
                    gap_mask_d = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
`ifdef HEX_SEQ_SKIP_UNCHANGED_EN
                shadow_d = act_val_q;
`endif
                // A start seen in DONE is the newest request and supersedes the pending one.
                if (start_i) begin
                    act_val_d  = value_i;
                    act_mask_d = mask_i;
                    pend_vld_d = 1'b0;
                    launch     = 1'b1;
                end else if (pend_vld_q) begin
                    act_val_d  = pend_val_q;
                    act_mask_d = pend_mask_q;
                    pend_vld_d = 1'b0;
                    launch     = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef HEX_SEQ_SKIP_UNCHANGED_EN
        changed = act_val_d ^ shadow_d;
`endif
        if (launch) begin
            tgt_idx = find_write(from_idx, changed);
            if (tgt_idx[3]) begin
                state_d = StMask;
            end else begin
                state_d = StDigit;
                idx_d   = tgt_idx[2:0];
            end
        end

        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        req_d   = (state_d == StDigit) || (state_d == StMask);
        addr_d  = 32'h0;
        wdata_d = 32'h0;
        if (state_d == StDigit) begin
            addr_d  = BASE_ADDR + {27'b0, idx_d, 2'b00};
            wdata_d = {28'b0, act_val_d[4*idx_d +: 4]};
        end else if (state_d == StMask) begin
            addr_d  = BASE_ADDR + 32'h20;
            wdata_d = {24'b0, act_mask_d};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            gap_cnt_q   <= 4'd0;
            gap_mask_q  <= 1'b0;
            act_val_q   <= 32'h0;
            act_mask_q  <= 8'h0;
            pend_val_q  <= 32'h0;
            pend_mask_q <= 8'h0;
            pend_vld_q  <= 1'b0;
`ifdef HEX_SEQ_SKIP_UNCHANGED_EN
            shadow_q    <= 32'h0;
`endif
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            req_o       <= 1'b0;
            we_o        <= 1'b0;
            addr_o      <= 32'h0;
            wdata_o     <= 32'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_mask_q  <= gap_mask_d;
            act_val_q   <= act_val_d;
            act_mask_q  <= act_mask_d;
            pend_val_q  <= pend_val_d;
            pend_mask_q <= pend_mask_d;
            pend_vld_q  <= pend_vld_d;
`ifdef HEX_SEQ_SKIP_UNCHANGED_EN
            shadow_q    <= shadow_d;
`endif
            busy_o      <= busy_d;
            done_o      <= done_d;
            req_o       <= req_d;
            we_o        <= req_d;
            addr_o      <= addr_d;
            wdata_o     <= wdata_d;
        end
    end

endmodule

// File: tb/tb_hex_update_seq.sv
// Directed bench for hex_update_seq: a GAP_CYCLES=0 instance plus a GAP_CYCLES=2 instance.
module tb_hex_update_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = 32'h0;
    logic [7:0]  mask = 8'h0;

    logic        busy0, done0, req0, we0;
    logic [31:0] addr0, wdata0;
    logic        busy2, done2, req2, we2;
    logic [31:0] addr2, wdata2;

    hex_update_seq #(.GAP_CYCLES(0), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .value_i(value), .mask_i(mask),
        .busy_o(busy0), .done_o(done0), .req_o(req0), .we_o(we0),
        .addr_o(addr0), .wdata_o(wdata0)
    );

    hex_update_seq #(.GAP_CYCLES(2), .BASE_ADDR(32'h0)) dut_gap (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .value_i(value), .mask_i(mask),
        .busy_o(busy2), .done_o(done2), .req_o(req2), .we_o(we2),
        .addr_o(addr2), .wdata_o(wdata2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          w0_cyc[$];
    logic [31:0] w0_addr[$];
    logic [31:0] w0_data[$];
    int          d0_cyc[$];
    int          w2_cyc[$];
    logic [31:0] w2_addr[$];
    logic [31:0] w2_data[$];
    int          d2_cyc[$];
    int          we_err = 0;
    int          idle_err = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req0) begin
                w0_cyc.push_back(cyc);
                w0_addr.push_back(addr0);
                w0_data.push_back(wdata0);
            end
            if (done0) d0_cyc.push_back(cyc);
            if (req2) begin
                w2_cyc.push_back(cyc);
                w2_addr.push_back(addr2);
                w2_data.push_back(wdata2);
            end
            if (done2) d2_cyc.push_back(cyc);
            if (we0 !== req0 || we2 !== req2) we_err++;
            if (!req0 && (addr0 != 32'h0 || wdata0 != 32'h0)) idle_err++;
            if (!req2 && (addr2 != 32'h0 || wdata2 != 32'h0)) idle_err++;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        w0_cyc.delete(); w0_addr.delete(); w0_data.delete(); d0_cyc.delete();
        w2_cyc.delete(); w2_addr.delete(); w2_data.delete(); d2_cyc.delete();
        step(1);
    endtask

    task automatic wait_done(input int n0, input int n2, input int budget, input string tag);
        int b;
        b = budget;
        while ((d0_cyc.size() < n0 || d2_cyc.size() < n2) && b > 0) begin
            step(1);
            b--;
        end
        check({tag, "_timeout"}, 32'(b > 0), 32'd1);
    endtask

    task automatic pulse(input logic [31:0] v, input logic [7:0] m);
        value = v;
        mask  = m;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int t0;
        int bcnt;
        int busy_drop;
        logic [31:0] exp_d[8];
        exp_d = '{32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};

        // Reset state
        do_reset();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_req", 32'(req0), 32'd0);
        check("rst_addr", addr0, 32'h0);
        check("rst_wdata", wdata0, 32'h0);

        // Single update, both gap settings
        t0 = cyc;
        pulse(32'h1234_5678, 8'hFF);
        check("busy_cycle1", 32'(busy0), 32'd1);
        wait_done(1, 1, 60, "single");
        check("g0_nwrites", 32'(w0_cyc.size()), 32'd9);
        for (int k = 0; k < 8 && k < w0_cyc.size(); k++) begin
            check($sformatf("g0_cyc%0d", k), 32'(w0_cyc[k] - t0), 32'(k + 1));
            check($sformatf("g0_addr%0d", k), w0_addr[k], 32'(4 * k));
            check($sformatf("g0_data%0d", k), w0_data[k], exp_d[k]);
        end
        if (w0_cyc.size() >= 9) begin
            check("g0_mask_cyc", 32'(w0_cyc[8] - t0), 32'd9);
            check("g0_mask_addr", w0_addr[8], 32'h20);
            check("g0_mask_data", w0_data[8], 32'hFF);
        end
        check("g0_done_cyc", 32'(d0_cyc[0] - t0), 32'd10);
        check("g2_nwrites", 32'(w2_cyc.size()), 32'd9);
        for (int k = 0; k < 9 && k < w2_cyc.size(); k++) begin
            check($sformatf("g2_cyc%0d", k), 32'(w2_cyc[k] - t0), 32'(1 + 3 * k));
        end
        if (w2_cyc.size() >= 9) begin
            check("g2_data3", w2_data[3], 32'h5);
            check("g2_mask_addr", w2_addr[8], 32'h20);
        end
        check("g2_done_cyc", 32'(d2_cyc[0] - t0), 32'd28);
        while (cyc < t0 + 11) step(1);
        check("idle_busy", 32'(busy0), 32'd0);

        // Newest pending request wins: A, B (dropped), C
        do_reset();
        t0 = cyc;
        pulse(32'hA, 8'h3C);
        step(2);
        pulse(32'hB, 8'h00);
        step(1);
        pulse(32'hC, 8'h81);
        wait_done(2, 0, 60, "abc");
        check("abc_nwrites", 32'(w0_cyc.size()), 32'd18);
        if (w0_cyc.size() >= 18) begin
            check("abc_a_data0", w0_data[0], 32'hA);
            check("abc_a_mask", w0_data[8], 32'h3C);
            check("abc_c_data0", w0_data[9], 32'hC);
            check("abc_c_cyc0", 32'(w0_cyc[9] - t0), 32'(d0_cyc[0] - t0 + 1));
            check("abc_c_mask", w0_data[17], 32'h81);
        end
        check("abc_a_done", 32'(d0_cyc[0] - t0), 32'd10);
        check("abc_c_done", 32'(d0_cyc[1] - t0), 32'd20);
        bcnt = 0;
        foreach (w0_data[i]) if (w0_addr[i] == 32'h0 && w0_data[i] == 32'hB) bcnt++;
        check("abc_no_b", 32'(bcnt), 32'd0);

        // Reset in the middle of a burst with a request pending
        do_reset();
        t0 = cyc;
        pulse(32'h1234_5678, 8'hFF);
        step(1);
        pulse(32'h0000_0009, 8'h0F);
        step(1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_req", 32'(req0), 32'd0);
        check("mid_rst_addr", addr0, 32'h0);
        check("mid_rst_wdata", wdata0, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(30);
        check("mid_rst_nwrites", 32'(w0_cyc.size()), 32'd3);
        check("mid_rst_ndone", 32'(d0_cyc.size()), 32'd0);
        check("mid_rst_idle", 32'(busy0), 32'd0);

        // Start held high: back-to-back bursts, busy never drops
        do_reset();
        t0 = cyc;
        value = 32'h55;
        mask = 8'hF0;
        start = 1'b1;
        busy_drop = 0;
        for (int i = 1; i < 40; i++) begin
            step(1);
            if (!busy0) busy_drop++;
        end
        start = 1'b0;
        check("held_busy_drop", 32'(busy_drop), 32'd0);
        check("held_ndone", 32'(d0_cyc.size()), 32'd3);
        check("held_restart", 32'(w0_cyc[9] - t0), 32'd11);

        check("we_follows_req", 32'(we_err), 32'd0);
        check("idle_bus_zero", 32'(idle_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
